background_tiler: RTL and testbench

- Parametrised tile-based background renderer, successor to the fixed single-bit background path.
- Converts VGA pixel coordinates into tile indices and a ROM address, then realigns the ROM data with a delayed copy of the pixel context.
- Supports configurable tile size, grid size, colour depth and ROM latency, plus horizontal scrolling and four render modes.
- Sits between the VGA timing generator and the colour mux in the VGA wrapper; the background ROM is external.

---
 rtl/background_tiler_if.sv | 33 +++
 rtl/background_tiler.sv | 169 ++++++++++++++++
 tb/tb_background_tiler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/background_tiler_if.sv
// Pixel-side bundle of the background tiler: VGA context in, ROM port, rendered pixel out.
// The master side is the VGA wrapper or bench; the slave side is the tiler.
interface background_tiler_if #(
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int COLOR_W = 2,
  parameter int ADDR_W  = $clog2(GRID_W * GRID_H),
  parameter int XC_W    = $clog2(GRID_W),
  parameter int YC_W    = $clog2(GRID_H)
);
  logic [9:0]         X;
  logic [9:0]         Y;
  logic               display_area;
  logic [1:0]         mode;
  logic [9:0]         scroll_x;
  logic [ADDR_W-1:0]  rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic [XC_W-1:0]    x_count;
  logic [YC_W-1:0]    y_count;
  logic [COLOR_W-1:0] pixel_color;
  logic               pixel_valid;
  logic               frame_tick;

  modport master (
    output X, Y, display_area, mode, scroll_x, rom_data,
    input  rom_addr, x_count, y_count, pixel_color, pixel_valid, frame_tick
  );

  modport slave (
    input  X, Y, display_area, mode, scroll_x, rom_data,
    output rom_addr, x_count, y_count, pixel_color, pixel_valid, frame_tick
  );
endinterface

// File: rtl/background_tiler.sv
// Tile-based background renderer: pixel coordinates -> tile/ROM address, ROM data realigned
// with a delayed pixel context, then coloured according to the per-frame render mode.
module background_tiler #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int TILE_W_LOG2  = 4,
  parameter int TILE_H_LOG2  = 4,
  parameter int GRID_W       = 40,
  parameter int GRID_H       = 30,
  parameter int COLOR_W      = 2,
  parameter int ROM_LATENCY  = 1,
  parameter int BORDER_COLOR = 0,
  parameter int GRID_COLOR   = 3,
  parameter int CHECK_A      = 1,
  parameter int CHECK_B      = 2,
  parameter int FILL_COLOR   = 1
) (
  input logic               clock_25,
  input logic               reset,
  background_tiler_if.slave bus
);

  localparam int ADDR_W = $clog2(GRID_W * GRID_H);
  localparam int XC_W   = $clog2(GRID_W);
  localparam int YC_W   = $clog2(GRID_H);

  localparam logic [10:0] GRID_PX_W = 11'(GRID_W << TILE_W_LOG2);
  localparam logic [10:0] GRID_PX_H = 11'(GRID_H << TILE_H_LOG2);
  localparam logic [9:0]  V_LINE    = 10'(V_ACTIVE);

  localparam logic [COLOR_W-1:0] C_BORDER = COLOR_W'(BORDER_COLOR);
  localparam logic [COLOR_W-1:0] C_GRID   = COLOR_W'(GRID_COLOR);
  localparam logic [COLOR_W-1:0] C_CHK_A  = COLOR_W'(CHECK_A);
  localparam logic [COLOR_W-1:0] C_CHK_B  = COLOR_W'(CHECK_B);
  localparam logic [COLOR_W-1:0] C_FILL   = COLOR_W'(FILL_COLOR);

  if ((GRID_W << TILE_W_LOG2) > 1023 || H_ACTIVE > 1023 || ROM_LATENCY < 1) begin : g_unsupported
    $error("background_tiler: unsupported geometry or ROM latency");
  end

  typedef enum logic [1:0] {
    MODE_ROM   = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_FILL  = 2'd3
  } mode_t;

  typedef struct packed {
    logic  disp;
    logic  in_grid;
    logic  line;
    logic  parity;
    mode_t mode;
  } ctx_t;

  logic [9:0]         scroll_reg;
  mode_t              mode_reg;
  logic               frame_tick;
  logic [ADDR_W-1:0]  rom_addr;
  logic [XC_W-1:0]    x_count;
  logic [YC_W-1:0]    y_count;
  logic [COLOR_W-1:0] pixel_color;
  logic               pixel_valid;
  ctx_t               s1;
  ctx_t               dly [ROM_LATENCY];

  logic               boundary;
  logic [9:0]         scroll_wrapped;
  logic [10:0]        xs_sum;
  logic [10:0]        xs;
  logic [XC_W-1:0]    x_count_next;
  logic [YC_W-1:0]    y_count_next;
  logic [ADDR_W-1:0]  addr_next;
  ctx_t               s1_next;
  ctx_t               ctx_out;
  logic [COLOR_W-1:0] color_next;
  logic               valid_next;

  always_comb begin
    boundary       = (bus.X == '0) && (bus.Y == V_LINE);
    scroll_wrapped = 10'({1'b0, bus.scroll_x} % GRID_PX_W);

    // X and scroll_reg are both below the grid width, so one subtract completes the wrap.
    xs_sum = {1'b0, bus.X} + {1'b0, scroll_reg};
    xs     = (xs_sum >= GRID_PX_W) ? xs_sum - GRID_PX_W : xs_sum;

    x_count_next = XC_W'(xs >> TILE_W_LOG2);
    y_count_next = YC_W'(bus.Y >> TILE_H_LOG2);
    addr_next    = ADDR_W'(32'(y_count_next) * GRID_W + 32'(x_count_next));

    s1_next         = '0;
    s1_next.disp    = bus.display_area;
    s1_next.in_grid = bus.display_area && ({1'b0, bus.Y} < GRID_PX_H);
    s1_next.line    = (xs[TILE_W_LOG2-1:0] == '0) || (bus.Y[TILE_H_LOG2-1:0] == '0);
    s1_next.parity  = x_count_next[0] ^ y_count_next[0];
    s1_next.mode    = mode_reg;
  end

  always_ff @(posedge clock_25) begin
    if (!reset) begin
      scroll_reg <= '0;
      mode_reg   <= MODE_ROM;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (boundary) begin
        scroll_reg <= scroll_wrapped;
        mode_reg   <= mode_t'(bus.mode);
      end
    end
  end

  always_ff @(posedge clock_25) begin
    if (!reset) begin
      s1       <= '0;
      rom_addr <= '0;
      x_count  <= '0;
      y_count  <= '0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) dly[i] <= '0;
    end else begin
      s1      <= s1_next;
      x_count <= x_count_next;
      y_count <= y_count_next;
      if (s1_next.in_grid) rom_addr <= addr_next;
      dly[0] <= s1;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  // Context leaving the delay line lines up with rom_data for the same pixel.
  assign ctx_out = dly[ROM_LATENCY-1];

  always_comb begin
    color_next = '0;
    valid_next = 1'b0;
    if (ctx_out.disp) begin
      valid_next = 1'b1;
      if (!ctx_out.in_grid) begin
        color_next = C_BORDER;
      end else begin
        unique case (ctx_out.mode)
          MODE_ROM:   color_next = bus.rom_data;
          MODE_CHECK: color_next = ctx_out.parity ? C_CHK_B : C_CHK_A;
          MODE_GRID:  color_next = ctx_out.line ? C_GRID : bus.rom_data;
          MODE_FILL:  color_next = C_FILL;
          default:    color_next = bus.rom_data;
        endcase
      end
    end
  end

  always_ff @(posedge clock_25) begin
    if (!reset) begin
      pixel_color <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_color <= color_next;
      pixel_valid <= valid_next;
    end
  end

  assign bus.rom_addr    = rom_addr;
  assign bus.x_count     = x_count;
  assign bus.y_count     = y_count;
  assign bus.pixel_color = pixel_color;
  assign bus.pixel_valid = pixel_valid;
  assign bus.frame_tick  = frame_tick;

endmodule

// File: tb/tb_background_tiler.sv
// Bench for background_tiler: two instances (ROM latency 1 / 30-row grid, ROM latency 3 / 20-row grid)
// driven in lockstep and compared with a per-pixel reference model plus directed scenarios.
module tb_background_tiler;
  logic       clk;
  logic       rst_n;
  logic [9:0] x_drv, y_drv, sc_drv;
  logic       disp_drv;
  logic [1:0] md_drv;

  int checks = 0;
  int errors = 0;

  background_tiler_if #(.GRID_W(40), .GRID_H(30), .COLOR_W(2)) ifa ();
  background_tiler_if #(.GRID_W(40), .GRID_H(20), .COLOR_W(2)) ifb ();

  background_tiler #(.ROM_LATENCY(1)) dut_a (.clock_25(clk), .reset(rst_n), .bus(ifa));
  background_tiler #(.ROM_LATENCY(3), .GRID_H(20)) dut_b (.clock_25(clk), .reset(rst_n), .bus(ifb));

  assign ifa.X = x_drv;  assign ifa.Y = y_drv;  assign ifa.display_area = disp_drv;
  assign ifa.mode = md_drv;  assign ifa.scroll_x = sc_drv;
  assign ifb.X = x_drv;  assign ifb.Y = y_drv;  assign ifb.display_area = disp_drv;
  assign ifb.mode = md_drv;  assign ifb.scroll_x = sc_drv;

  // ROMs return the low two address bits after their respective latencies.
  logic [1:0] rom_a;
  logic [1:0] rom_b [3];
  always @(posedge clk) begin
    rom_a    <= ifa.rom_addr[1:0];
    rom_b[0] <= ifb.rom_addr[1:0];
    rom_b[1] <= rom_b[0];
    rom_b[2] <= rom_b[1];
  end
  assign ifa.rom_data = rom_a;
  assign ifb.rom_data = rom_b[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: latched frame settings and expected outputs after the most recent edge.
  int m_scroll = 0, m_mode = 0;
  int qa[$], qb[$];
  int exp_a, exp_b, exp_tick, exp_xc, exp_yc, exp_addr_a, exp_addr_b;

  // Expected {valid, color} packed as valid*4 + color for one pixel.
  function automatic int ref_pix(input bit disp, input bit ing, input int md, input int s, input int y);
    int rom, c;
    if (!disp) return 0;
    if (!ing) return 4 + 0;
    rom = ((y / 16) * 40 + s / 16) % 4;
    case (md)
      0: c = rom;
      1: c = (((s / 16) + (y / 16)) % 2 == 1) ? 2 : 1;
      2: c = (s % 16 == 0 || y % 16 == 0) ? 3 : rom;
      default: c = 1;
    endcase
    return 4 + c;
  endfunction

  task automatic cycle(input bit rn, input int x, input int y, input int md, input int sc);
    int s;
    bit disp, ing_a, ing_b;
    rst_n = rn; x_drv = 10'(x); y_drv = 10'(y); md_drv = 2'(md); sc_drv = 10'(sc);
    disp = (x < 640) && (y < 480);
    disp_drv = disp;
    @(posedge clk);
    if (!rn) begin
      m_scroll = 0; m_mode = 0;
      qa.delete(); qb.delete();
      repeat (2) qa.push_back(0);
      repeat (4) qb.push_back(0);
      exp_a = 0; exp_b = 0; exp_tick = 0; exp_xc = 0; exp_yc = 0; exp_addr_a = 0; exp_addr_b = 0;
    end else begin
      s = x + m_scroll;
      if (s >= 640) s -= 640;
      exp_xc = (s / 16) % 64;
      exp_yc = (y / 16) % 32;
      ing_a = disp && (y < 480);
      ing_b = disp && (y < 320);
      if (ing_a) exp_addr_a = ((y / 16) * 40 + s / 16) % 2048;
      if (ing_b) exp_addr_b = ((y / 16) * 40 + s / 16) % 1024;
      exp_a = qa.pop_front(); qa.push_back(ref_pix(disp, ing_a, m_mode, s, y));
      exp_b = qb.pop_front(); qb.push_back(ref_pix(disp, ing_b, m_mode, s, y));
      exp_tick = (x == 0 && y == 480) ? 1 : 0;
      if (x == 0 && y == 480) begin
        m_scroll = sc % 640;
        m_mode = md;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int first_a, first_b;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 100 + 50 * i, 40 + 60 * i, 3, 200);
      checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'd0) begin errors++; $display("FAIL reset_pix_a got %0d exp 0", {ifa.pixel_valid, ifa.pixel_color}); end
      checks++; if ({ifb.pixel_valid, ifb.pixel_color} !== 3'd0) begin errors++; $display("FAIL reset_pix_b got %0d exp 0", {ifb.pixel_valid, ifb.pixel_color}); end
      checks++; if (ifa.rom_addr !== 11'd0 || ifb.rom_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d exp 0", ifa.rom_addr, ifb.rom_addr); end
      checks++; if (ifa.x_count !== 6'd0 || ifa.y_count !== 5'd0 || ifa.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0", ifa.x_count, ifa.y_count, ifa.frame_tick); end
    end
    first_a = -1; first_b = -1;
    for (int n = 1; n <= 8; n++) begin
      cycle(1, 100, 100, 0, 0);
      if (first_a < 0 && ifa.pixel_valid === 1'b1) first_a = n;
      if (first_b < 0 && ifb.pixel_valid === 1'b1) first_b = n;
    end
    checks++; if (first_a !== 3) begin errors++; $display("FAIL latency_a got %0d exp 3", first_a); end
    checks++; if (first_b !== 5) begin errors++; $display("FAIL latency_b got %0d exp 5", first_b); end
  endtask

  task automatic test_mode0_latency();
    repeat (5) cycle(1, 700, 50, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) cycle(1, 37, 50, 0, 0); else cycle(1, 700, 50, 0, 0);
      if (k == 1) begin
        checks++; if (ifa.rom_addr !== 11'd122 || ifb.rom_addr !== 10'd122) begin errors++; $display("FAIL m0_addr got %0d/%0d exp 122", ifa.rom_addr, ifb.rom_addr); end
        checks++; if (ifa.x_count !== 6'd2 || ifa.y_count !== 5'd3) begin errors++; $display("FAIL m0_cnt got %0d,%0d exp 2,3", ifa.x_count, ifa.y_count); end
      end
      checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== ((k == 3) ? 3'b110 : 3'b000)) begin errors++; $display("FAIL m0_pix_a k=%0d got %0d exp %0d", k, {ifa.pixel_valid, ifa.pixel_color}, (k == 3) ? 6 : 0); end
      checks++; if ({ifb.pixel_valid, ifb.pixel_color} !== ((k == 5) ? 3'b110 : 3'b000)) begin errors++; $display("FAIL m0_pix_b k=%0d got %0d exp %0d", k, {ifb.pixel_valid, ifb.pixel_color}, (k == 5) ? 6 : 0); end
    end
  endtask

  task automatic test_scroll_wrap();
    cycle(1, 0, 480, 0, 630);
    checks++; if (ifa.frame_tick !== 1'b1 || ifb.frame_tick !== 1'b1) begin errors++; $display("FAIL tick_high got %0d/%0d exp 1", ifa.frame_tick, ifb.frame_tick); end
    cycle(1, 20, 50, 0, 0);
    checks++; if (ifa.frame_tick !== 1'b0) begin errors++; $display("FAIL tick_low got %0d exp 0", ifa.frame_tick); end
    checks++; if (ifa.x_count !== 6'd0) begin errors++; $display("FAIL wrap_x20 got %0d exp 0", ifa.x_count); end
    cycle(1, 5, 50, 0, 0);
    checks++; if (ifa.x_count !== 6'd39 || ifa.rom_addr !== 11'd159) begin errors++; $display("FAIL wrap_x5 got %0d,%0d exp 39,159", ifa.x_count, ifa.rom_addr); end
  endtask

  task automatic test_deferred_mode();
    int ticks;
    cycle(1, 0, 480, 0, 0);
    ticks = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) cycle(1, 0, 100, 1, 0); else if (k == 2) cycle(1, 16, 100, 1, 0); else cycle(1, 700, 100, 1, 0);
      ticks += int'(ifa.frame_tick);
      if (k == 3) begin checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'b100) begin errors++; $display("FAIL defer_t0 got %0d exp 4", {ifa.pixel_valid, ifa.pixel_color}); end end
      if (k == 4) begin checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'b101) begin errors++; $display("FAIL defer_t1 got %0d exp 5", {ifa.pixel_valid, ifa.pixel_color}); end end
    end
    for (int k = 0; k < 6; k++) begin cycle(1, 300 + k, 479, 1, 0); ticks += int'(ifa.frame_tick); end
    cycle(1, 0, 480, 1, 0); ticks += int'(ifa.frame_tick);
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) cycle(1, 0, 0, 0, 0); else if (k == 2) cycle(1, 16, 0, 0, 0); else cycle(1, 700, 0, 0, 0);
      ticks += int'(ifa.frame_tick);
      if (k == 3) begin checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'b101) begin errors++; $display("FAIL check_a got %0d exp 5", {ifa.pixel_valid, ifa.pixel_color}); end end
      if (k == 4) begin checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'b110) begin errors++; $display("FAIL check_b got %0d exp 6", {ifa.pixel_valid, ifa.pixel_color}); end end
    end
    checks++; if (ticks !== 1) begin errors++; $display("FAIL tick_count got %0d exp 1", ticks); end
  endtask

  task automatic test_border_grid();
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) cycle(1, 100, 330, 0, 0); else cycle(1, 700, 330, 0, 0);
    end
    checks++; if ({ifb.pixel_valid, ifb.pixel_color} !== 3'b100) begin errors++; $display("FAIL border_b got %0d exp 4", {ifb.pixel_valid, ifb.pixel_color}); end
    cycle(1, 0, 480, 2, 0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) cycle(1, 16, 5, 0, 0); else if (k == 2) cycle(1, 17, 5, 0, 0); else cycle(1, 700, 5, 0, 0);
      if (k == 3) begin checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'b111) begin errors++; $display("FAIL gridline_a got %0d exp 7", {ifa.pixel_valid, ifa.pixel_color}); end end
      if (k == 4) begin checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'b101) begin errors++; $display("FAIL gridrom_a got %0d exp 5", {ifa.pixel_valid, ifa.pixel_color}); end end
      if (k == 5) begin checks++; if ({ifb.pixel_valid, ifb.pixel_color} !== 3'b111) begin errors++; $display("FAIL gridline_b got %0d exp 7", {ifb.pixel_valid, ifb.pixel_color}); end end
      if (k == 6) begin checks++; if ({ifb.pixel_valid, ifb.pixel_color} !== 3'b101) begin errors++; $display("FAIL gridrom_b got %0d exp 5", {ifb.pixel_valid, ifb.pixel_color}); end end
    end
  endtask

  task automatic test_mid_reset();
    cycle(1, 0, 480, 3, 8);
    cycle(1, 10, 200, 0, 0);
    checks++; if (ifa.x_count !== 6'd1) begin errors++; $display("FAIL pre_rst_x got %0d exp 1", ifa.x_count); end
    cycle(1, 700, 200, 0, 0); cycle(1, 700, 200, 0, 0);
    checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'b101) begin errors++; $display("FAIL pre_rst_fill got %0d exp 5", {ifa.pixel_valid, ifa.pixel_color}); end
    cycle(0, 200, 200, 3, 8);
    cycle(1, 10, 200, 3, 8);
    checks++; if (ifa.x_count !== 6'd0) begin errors++; $display("FAIL post_rst_x got %0d exp 0", ifa.x_count); end
    cycle(1, 700, 200, 3, 8); cycle(1, 700, 200, 3, 8);
    checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'b100) begin errors++; $display("FAIL post_rst_m0 got %0d exp 4", {ifa.pixel_valid, ifa.pixel_color}); end
  endtask

  task automatic test_random();
    bit rn;
    int x, y;
    for (int n = 0; n < 3000; n++) begin
      rn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) begin x = 0; y = 480; end
      else begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
      cycle(rn, x, y, $urandom_range(0, 3), $urandom_range(0, 1023));
      checks++; if ({ifa.pixel_valid, ifa.pixel_color} !== 3'(exp_a)) begin errors++; $display("FAIL rnd_pix_a n=%0d got %0d exp %0d", n, {ifa.pixel_valid, ifa.pixel_color}, exp_a); end
      checks++; if ({ifb.pixel_valid, ifb.pixel_color} !== 3'(exp_b)) begin errors++; $display("FAIL rnd_pix_b n=%0d got %0d exp %0d", n, {ifb.pixel_valid, ifb.pixel_color}, exp_b); end
      checks++; if (ifa.rom_addr !== 11'(exp_addr_a)) begin errors++; $display("FAIL rnd_addr_a n=%0d got %0d exp %0d", n, ifa.rom_addr, exp_addr_a); end
      checks++; if (ifb.rom_addr !== 10'(exp_addr_b)) begin errors++; $display("FAIL rnd_addr_b n=%0d got %0d exp %0d", n, ifb.rom_addr, exp_addr_b); end
      checks++; if (ifa.x_count !== 6'(exp_xc) || ifa.y_count !== 5'(exp_yc)) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d,%0d exp %0d,%0d", n, ifa.x_count, ifa.y_count, exp_xc, exp_yc); end
      checks++; if (ifa.frame_tick !== 1'(exp_tick) || ifb.frame_tick !== 1'(exp_tick)) begin errors++; $display("FAIL rnd_tick n=%0d got %0d/%0d exp %0d", n, ifa.frame_tick, ifb.frame_tick, exp_tick); end
    end
  endtask

  initial begin
    rst_n = 1'b0; x_drv = '0; y_drv = '0; disp_drv = 1'b0; md_drv = '0; sc_drv = '0;
    #2;
    test_reset();
    test_mode0_latency();
    test_scroll_wrap();
    test_deferred_mode();
    test_border_grid();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
